// File: rtl/dec_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dec_scan_pkg
// Description : Shared state encoding and decode helpers for dec_scan_n.
// Revision    : 1.0 - initial release
// ============================================================================
package dec_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Widest strobe vector the helpers can build (SEL_W up to 8).
    localparam int unsigned c_max_out_w = 256;

    function automatic logic [c_max_out_w-1:0] onehot(input int unsigned index,
                                                      input int unsigned width);
        logic [c_max_out_w-1:0] v;
        v = '0;
        if (index < width && index < c_max_out_w) begin
            v[index[7:0]] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [c_max_out_w-1:0] inactive_vec(input logic active_low);
        return {c_max_out_w{active_low}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : dec_scan_if
// Description : Select handshake, control and strobe outputs of dec_scan_n.
// Revision    : 1.0 - initial release
// ============================================================================
interface dec_scan_if #(
    parameter int SEL_W = 4
);
    localparam int OUT_W = 2 ** SEL_W;

    logic             en;
    logic             mode;
    logic             sel_valid;
    logic [SEL_W-1:0] sel;
    logic             sel_ready;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (
        output en, mode, sel_valid, sel,
        input  sel_ready, out, idx, wrap
    );

    modport slave (
        input  en, mode, sel_valid, sel,
        output sel_ready, out, idx, wrap
    );

endinterface
`default_nettype wire

// File: rtl/dec_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : dec_scan_timer
// Description : Dwell counter 0..DWELL-1 with clear and terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_scan_timer #(
    parameter int DWELL = 3,
    parameter int CNT_W = 16
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_cnt_en,
    input  wire  i_clr,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_cnt_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/dec_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : dec_scan_n
// Description : Registered SEL_W-to-2^SEL_W decoder with select handshake,
//               selectable polarity and an auto-scan mode with dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_scan_n
    import dec_scan_pkg::*;
#(
    parameter int SEL_W      = 4,
    parameter int DWELL      = 3,
    parameter int ACTIVE_LOW = 0
) (
    input wire        clk,
    input wire        rst,
    dec_scan_if.slave bus
);

    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [OUT_W-1:0] c_inactive = OUT_W'(inactive_vec(ACTIVE_LOW != 0));

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] w_idx_nxt;
    logic [SEL_W-1:0] w_idx_inc;
    logic [OUT_W-1:0] r_vec;
    logic [OUT_W-1:0] w_vec_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic             w_tmr_en;
    logic             w_tmr_clr;
    logic             w_tc;
    logic             w_ready;

    dec_scan_timer #(
        .DWELL (DWELL),
        .CNT_W (16)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_cnt_en (w_tmr_en),
        .i_clr    (w_tmr_clr),
        .o_tc     (w_tc)
    );

    assign w_idx_inc = r_idx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_vec   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_vec   <= w_vec_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // r_vec is the active-high strobe; polarity is applied only at the port.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_vec_nxt   = r_vec;
        w_wrap_nxt  = 1'b0;
        w_tmr_en    = 1'b0;
        w_tmr_clr   = 1'b0;
        w_ready     = 1'b0;
        if (!bus.en) begin
            w_vec_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_vec_nxt = '0;
                    if (bus.mode) begin
                        w_state_nxt = SCAN;
                        w_idx_nxt   = '0;
                        w_vec_nxt   = OUT_W'(onehot(0, OUT_W));
                        w_tmr_clr   = 1'b1;
                    end else begin
                        w_state_nxt = DIRECT;
                    end
                end
                DIRECT: begin
                    w_ready = 1'b1;
                    if (bus.mode) begin
                        w_state_nxt = SCAN;
                        w_idx_nxt   = '0;
                        w_vec_nxt   = OUT_W'(onehot(0, OUT_W));
                        w_tmr_clr   = 1'b1;
                    end else if (bus.sel_valid) begin
                        w_idx_nxt = bus.sel;
                        w_vec_nxt = OUT_W'(onehot(32'(bus.sel), OUT_W));
                    end
                end
                SCAN: begin
                    if (!bus.mode) begin
                        w_state_nxt = DIRECT;
                        w_vec_nxt   = '0;
                    end else begin
                        w_tmr_en = 1'b1;
                        if (w_tc) begin
                            w_idx_nxt  = w_idx_inc;
                            w_vec_nxt  = OUT_W'(onehot(32'(w_idx_inc), OUT_W));
                            w_wrap_nxt = &r_idx;
                        end else begin
                            w_vec_nxt = OUT_W'(onehot(32'(r_idx), OUT_W));
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_vec_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.sel_ready = w_ready;
    assign bus.out       = r_vec ^ c_inactive;
    assign bus.idx       = r_idx;
    assign bus.wrap      = r_wrap;

endmodule
`default_nettype wire

// File: doc/dec_scan_n.md
# dec_scan_n

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a handshake on its select input and a built-in auto-scan mode. It generalises the fixed 4-to-16 combinational decoder: outputs are registered, polarity is selectable, and in scan mode the block steps one active output through every position with a programmable dwell. It sits between control logic and multiplexed loads such as display digit or row strobes and bank selects.

## Interface
- SEL_W, 4, select width; OUT_W = 2**SEL_W is a derived localparam.
- DWELL, 3, cycles each output stays active in scan mode; legal range 1..2**16-1.
- ACTIVE_LOW, 0, when 1 the inactive level is 1 and the active bit is 0.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  block enable; 0 forces outputs inactive and freezes scan state.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- sel_valid  in  1  select request valid.
- sel  in  SEL_W  requested output index.
- sel_ready  out  1  accepts sel; a transfer occurs when sel_valid and sel_ready are both 1.
- out  out  OUT_W  one-hot (or one-cold) strobe vector, registered.
- idx  out  SEL_W  index currently driven active; registered.
- wrap  out  1  one-cycle pulse when scan wraps from OUT_W-1 to 0.

## Operation
- FSM states: IDLE, DIRECT, SCAN.
- Reset: state IDLE, out all inactive, idx 0, wrap 0, sel_ready 0, dwell counter 0.
- IDLE: out inactive. With en=1: mode=0 -> DIRECT; mode=1 -> SCAN with idx 0 and dwell counter 0.
- DIRECT:
  - sel_ready = en, combinational from en and state.
  - On a transfer, idx <= sel and out <= onehot(sel).
  - Without a transfer, out and idx hold.
  - mode=1 -> SCAN, restarting at idx 0.
- SCAN:
  - sel_ready = 0.
  - out = onehot(idx); the dwell counter counts 0..DWELL-1.
  - When the counter reaches DWELL-1, it returns to 0 and idx increments. OUT_W-1 wraps to 0, and wrap is asserted for that cycle.
  - mode=0 -> DIRECT, with out set inactive until the first transfer.
- en=0 in any state:
  - out inactive, sel_ready 0, wrap 0.
  - state, idx and dwell counter hold.
  - On re-enable, scan resumes mid-dwell with the same idx.
- mode and en sampled together: the en=0 rule takes precedence.
- rst takes precedence over everything, including a same-cycle transfer.
- ACTIVE_LOW inverts only out. idx, wrap and the handshake are unaffected.
- At most one bit of out is active at any time.

## Timing
- Direct latency: transfer in cycle N -> out and idx updated after edge N, visible in cycle N+1.
- Back-to-back transfers allowed every cycle; throughput is 1 select per cycle.
- Scan:
  - First strobe (idx 0) is visible the cycle after SCAN is entered.
  - Each index is active for exactly DWELL cycles; full period OUT_W*DWELL cycles.
  - wrap is high during the first cycle of idx 0 after a wrap. It is not asserted on initial entry.
- Mode switch takes effect one cycle after mode is sampled changed.
- rst mid-scan: the next cycle shows all outputs inactive, idx 0.

## Structure
- Package dec_scan_pkg: state enum (IDLE, DIRECT, SCAN), function onehot(index, width), inactive-level constant helper.
- Sub-module dec_scan_timer: DWELL counter with en/clear inputs and a terminal-count output, reused by scan stepping.
- Top: FSM, idx register, output register with polarity XOR.

## Test plan
- Reset then en=1, mode=0, sel=0..15 one per cycle with sel_valid=1:
  - out = 16'h0001, 16'h0002 ... 16'h8000, each one cycle after its transfer.
  - sel_ready is constantly 1.
- mode=1, DWELL=3, SEL_W=4: idx 0..15 each held 3 cycles; wrap pulses once, 48 cycles after the first strobe; never two bits active.
- Scan at idx 5 mid-dwell, drop en for 4 cycles:
  - out is 0 during the gap and idx holds 5.
  - After re-enable, the remaining dwell cycles complete and then idx advances to 6.
- ACTIVE_LOW=1, SEL_W=2, direct sel=2 -> out = 4'b1011. With en=0 -> out = 4'b1111.
- Assert rst in the same cycle as a sel=9 transfer -> next cycle out=0, idx=0, state IDLE; sel=9 is not applied.
- DWELL=1, switch mode 1->0 mid-scan -> idx changes every cycle. After the switch, out is 0 until the next transfer, and sel_ready is 1 one cycle after the switch.
